// File: rtl/cond_unit.sv
// Conditional-execution unit for the execute stage of an ARM-style pipeline.
// Holds the architectural NZCV flags and evaluates the current condition
// field against them. It gates the decode controls and registers them into
// the memory stage. It also keeps saturating counts of executed and
// squashed instructions.
module cond_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ValidE,
   input  logic             StallE,
   input  logic             FlushE,
   input  logic [3:0]       CondE,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagWriteE,
   input  logic             PCSE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic             CntClr,
   output logic [3:0]       Flags,
   output logic             CondExE,
   output logic             PCSrcE,
   output logic             PCSrcM,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic             ValidM,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SkipCnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       flags_q, flags_d;
   logic             n_f, z_f, c_f, v_f;
   logic             cond_ex;
   logic             advance, exec, skip;
   logic             pcsrc_m_q, pcsrc_m_d;
   logic             regwrite_m_q, regwrite_m_d;
   logic             memwrite_m_q, memwrite_m_d;
   logic             valid_m_q, valid_m_d;
   logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

   // Conditions always look at the committed flags, never at this cycle's ALU result.
   assign {n_f, z_f, c_f, v_f} = flags_q;

   // Decode the 4-bit condition field; the reserved code 0xF never executes.
   always_comb begin
      cond_ex = 1'b0;
      case (CondE)
         4'h0:    cond_ex = z_f;
         4'h1:    cond_ex = ~z_f;
         4'h2:    cond_ex = c_f;
         4'h3:    cond_ex = ~c_f;
         4'h4:    cond_ex = n_f;
         4'h5:    cond_ex = ~n_f;
         4'h6:    cond_ex = v_f;
         4'h7:    cond_ex = ~v_f;
         4'h8:    cond_ex = c_f & ~z_f;
         4'h9:    cond_ex = ~(c_f & ~z_f);
         4'hA:    cond_ex = (n_f == v_f);
         4'hB:    cond_ex = (n_f != v_f);
         4'hC:    cond_ex = ~z_f & (n_f == v_f);
         4'hD:    cond_ex = ~(~z_f & (n_f == v_f));
         4'hE:    cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // An instruction leaves E only when it is valid, not stalled and not
   // flushed. Flush wins over stall.
   assign advance = ValidE & ~StallE & ~FlushE;
   assign exec    = advance & cond_ex;
   assign skip    = advance & ~cond_ex;

   // The branch request is not held back by a stall; the fetch side decides what to do with it.
   assign PCSrcE  = PCSE & cond_ex & ValidE & ~FlushE;
   assign CondExE = cond_ex;

   // Flag next-state: the N,Z pair and the C,V pair have independent write enables.
   always_comb begin
      flags_d = flags_q;
      if (exec) begin
         if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
         if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
      end
   end

   // Memory-stage controls: a bubble when nothing advances, gated controls otherwise.
   always_comb begin
      valid_m_d    = advance;
      regwrite_m_d = advance & RegWriteE & cond_ex;
      memwrite_m_d = advance & MemWriteE & cond_ex;
      pcsrc_m_d    = advance & PCSE & cond_ex;
   end

   // Saturating counters. A clear takes priority over an increment in the same cycle.
   always_comb begin
      exec_cnt_d = exec_cnt_q;
      skip_cnt_d = skip_cnt_q;
      if (CntClr) begin
         exec_cnt_d = '0;
         skip_cnt_d = '0;
      end else begin
         if (exec && exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_ONE;
         if (skip && skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_ONE;
      end
   end

   // State registers; reset clears everything at once, without waiting for an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q      <= 4'b0000;
         valid_m_q    <= 1'b0;
         regwrite_m_q <= 1'b0;
         memwrite_m_q <= 1'b0;
         pcsrc_m_q    <= 1'b0;
         exec_cnt_q   <= '0;
         skip_cnt_q   <= '0;
      end else begin
         flags_q      <= flags_d;
         valid_m_q    <= valid_m_d;
         regwrite_m_q <= regwrite_m_d;
         memwrite_m_q <= memwrite_m_d;
         pcsrc_m_q    <= pcsrc_m_d;
         exec_cnt_q   <= exec_cnt_d;
         skip_cnt_q   <= skip_cnt_d;
      end
   end

   assign Flags     = flags_q;
   assign ValidM    = valid_m_q;
   assign RegWriteM = regwrite_m_q;
   assign MemWriteM = memwrite_m_q;
   assign PCSrcM    = pcsrc_m_q;
   assign ExecCnt   = exec_cnt_q;
   assign SkipCnt   = skip_cnt_q;

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter CNT_W, default 16: width of the executed and squashed instruction counters; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ValidE  input  1  execute stage holds a real instruction.
REQ-005 StallE  input  1  execute stage stalled this cycle; instruction does not advance.
REQ-006 FlushE  input  1  execute-stage instruction killed this cycle.
REQ-007 CondE  input  4  ARM condition field of the execute-stage instruction.
REQ-008 ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-009 FlagWriteE  input  2  bit1 enables the N,Z write; bit0 enables the C,V write.
REQ-010 PCSE, RegWriteE, MemWriteE  input  1 each  ungated decode controls.
REQ-011 CntClr  input  1  synchronous clear of both counters.
REQ-012 Flags  output  4  architectural {N,Z,C,V} register.
REQ-013 CondExE  output  1  combinational condition result for the execute-stage instruction.
REQ-014 PCSrcE  output  1  combinational gated branch/PC write.
REQ-015 PCSrcM, RegWriteM, MemWriteM, ValidM  output  1 each  registered gated controls, memory stage.
REQ-016 ExecCnt, SkipCnt  output  CNT_W each  executed and squashed instruction counts.

Function
REQ-017 CondExE is evaluated against the current Flags register (pre-update), never ALUFlags.
REQ-018 Condition codes: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~(C&~Z); A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE ~(~Z&(N==V)); E AL 1; F gives 0 (no X).
REQ-019 Advance = ValidE & ~StallE & ~FlushE; Exec = Advance & CondExE; Skip = Advance & ~CondExE.
REQ-020 PCSrcE = PCSE & CondExE & ValidE & ~FlushE; it is independent of StallE.
REQ-021 On a clock edge with Exec=1, Flags[3:2] take ALUFlags[3:2] if FlagWriteE[1], and Flags[1:0] take ALUFlags[1:0] if FlagWriteE[0]; otherwise Flags hold.
REQ-022 A flag write by instruction k becomes visible to instruction k+1 on the next cycle, with zero bypass latency, because the register updates at the same edge k leaves E.
REQ-023 M register, one-cycle latency, on every edge: if Advance, ValidM=1, RegWriteM=RegWriteE&CondExE, MemWriteM=MemWriteE&CondExE, PCSrcM=PCSE&CondExE; else all four load 0 (bubble).
REQ-024 A squashed instruction (Skip) still produces ValidM=1, with all three gated controls 0.
REQ-025 ExecCnt increments by 1 on Exec; SkipCnt increments by 1 on Skip.
REQ-026 Both counters saturate at 2^CNT_W-1; they do not wrap.
REQ-027 CntClr=1 zeroes both counters at the edge; clear wins over a simultaneous increment.
REQ-028 FlushE and StallE both high: flush dominates; no flag write, no count, bubble to M.

Reset
REQ-029 While reset is high, independent of clk: Flags=0000, PCSrcM=RegWriteM=MemWriteM=ValidM=0, ExecCnt=SkipCnt=0.
REQ-030 Reset asserted mid-instruction discards that instruction; it produces no flag write and no count.
REQ-031 The first edge after reset deassertion operates normally on the inputs present.
REQ-032 CondExE and PCSrcE remain combinational during reset and evaluate against Flags=0000.

Verification
REQ-033 Reset, then CondE=0 (EQ), ValidE=1 -> CondExE=0, ValidM=1 and RegWriteM=0 next cycle, SkipCnt=1.
REQ-034 CondE=E, FlagWriteE=11, ALUFlags=0100 -> Flags=0100 next cycle; then CondE=0, RegWriteE=1 -> RegWriteM=1, ExecCnt=2.
REQ-035 Flags=1000, FlagWriteE=01, ALUFlags=0011, CondE=E -> Flags=1011 (N,Z held, C,V updated); CondE=A (GE) next -> CondExE=1.
REQ-036 StallE=1 with CondE=E, FlagWriteE=11 -> Flags unchanged, ValidM=0, counters unchanged; FlushE=1 with PCSE=1 -> PCSrcE=0.
REQ-037 CNT_W=4, 17 consecutive AL instructions -> ExecCnt=15; CntClr=1 together with an Exec -> ExecCnt=0.
REQ-038 Assert reset asynchronously between edges while ValidM=1 and Flags=1111 -> outputs clear immediately, before the next edge.
